// File: rtl/mux_cfg_loader_if.sv
// Host-side programming bus for mux_cfg_loader: the indexed write stream, the commit handshake
// and the registered select buses that feed the mux trees.
interface mux_cfg_loader_if #(
    parameter int unsigned NUM_MUX = 8,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned IDX_W   = 5
);
    logic                       wr_valid;
    logic                       wr_ready;
    logic [ADDR_W-1:0]          wr_addr;
    logic [IDX_W-1:0]           wr_idx;
    logic                       commit_req;
    logic                       commit_ack;
    logic [NUM_MUX*SEL_W-1:0]   sram;
    logic [NUM_MUX*SEL_W-1:0]   sram_inv;
    logic [NUM_MUX-1:0]         written_mask;
    logic                       cfg_done;
    logic                       cfg_err;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_idx,
        output commit_req,
        input  wr_ready,
        input  commit_ack,
        input  sram,
        input  sram_inv,
        input  written_mask,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_idx,
        input  commit_req,
        output wr_ready,
        output commit_ack,
        output sram,
        output sram_inv,
        output written_mask,
        output cfg_done,
        output cfg_err
    );
endinterface

// File: rtl/mux_cfg_loader.sv
// Shadow-bank configuration loader for OpenFPGA-style mux trees: indexed writes land in a shadow
// bank, and a commit handshake copies the whole bank to the active sram/sram_inv buses at once.
module mux_cfg_loader #(
    parameter int unsigned NUM_MUX  = 8,
    parameter int unsigned MUX_SIZE = 15,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned IDX_W    = 5
) (
    input  logic            prog_clk,
    input  logic            pReset,
    mux_cfg_loader_if.slave bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StCommit = 2'd1;
    localparam logic [1:0] StAck    = 2'd2;

    localparam logic [IDX_W-1:0]  MuxSizeIdx = IDX_W'(MUX_SIZE);
    localparam logic [ADDR_W:0]   NumMuxAddr = (ADDR_W + 1)'(NUM_MUX);

    logic [1:0]                       r_state;
    logic [1:0]                       w_state_next;
    logic [NUM_MUX-1:0][SEL_W-1:0]    r_shadow;
    logic [NUM_MUX-1:0][SEL_W-1:0]    r_sram;
    logic [NUM_MUX-1:0][SEL_W-1:0]    r_sram_inv;
    logic [NUM_MUX-1:0]               r_mask;
    logic                             r_err;

    logic                             w_wr_ready;
    logic                             w_wr_fire;
    logic                             w_addr_ok;
    logic                             w_idx_ok;
    logic [SEL_W-1:0]                 w_code;

    assign w_wr_ready = (r_state == StIdle);
    assign w_wr_fire  = bus.wr_valid & w_wr_ready;
    assign w_addr_ok  = ({1'b0, bus.wr_addr} < NumMuxAddr);
    assign w_idx_ok   = (bus.wr_idx < MuxSizeIdx);
    // in[i] is reached by code MUX_SIZE-i; an illegal index parks the mux on its const1 leaf.
    assign w_code     = w_idx_ok ? SEL_W'(MuxSizeIdx - bus.wr_idx) : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (bus.commit_req) w_state_next = StCommit;
            StCommit: w_state_next = StAck;
            StAck:    w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_shadow <= '0;
            r_mask   <= '0;
        end else if (r_state == StCommit) begin
            r_mask <= '0;
        end else if (w_wr_fire && w_addr_ok) begin
            for (int unsigned m = 0; m < NUM_MUX; m++) begin
                if (bus.wr_addr == ADDR_W'(m)) begin
                    r_shadow[m] <= w_code;
                    r_mask[m]   <= 1'b1;
                end
            end
        end
    end

    // Both polarities load on the same edge so the tree never sees a mixed select.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_sram     <= '0;
            r_sram_inv <= '1;
        end else if (r_state == StCommit) begin
            r_sram     <= r_shadow;
            r_sram_inv <= ~r_shadow;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_err <= 1'b0;
        end else if (w_wr_fire && (!w_addr_ok || !w_idx_ok)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.wr_ready     = w_wr_ready;
    assign bus.commit_ack   = (r_state == StAck);
    assign bus.sram         = r_sram;
    assign bus.sram_inv     = r_sram_inv;
    assign bus.written_mask = r_mask;
    assign bus.cfg_done     = &r_mask;
    assign bus.cfg_err      = r_err;

endmodule

// File: tb/tb_mux_cfg_loader.sv
// Randomised self-checking bench for mux_cfg_loader against an array-based model of the shadow
// bank, active bank, write mask and error flag.
module tb_mux_cfg_loader;

    localparam int NM = 8;

    logic prog_clk;
    logic pReset;

    mux_cfg_loader_if #(.NUM_MUX(8), .SEL_W(4), .ADDR_W(3), .IDX_W(5)) bus_if ();

    mux_cfg_loader #(
        .NUM_MUX  (8),
        .MUX_SIZE (15),
        .SEL_W    (4),
        .ADDR_W   (3),
        .IDX_W    (5)
    ) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .bus      (bus_if.slave)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int n_checks = 0;
    int n_errors = 0;

    int         exp_shadow [NM];
    int         exp_active [NM];
    logic [7:0] exp_mask;
    logic       exp_err;

    function automatic int code_of(input int idx);
        return (idx < 15) ? (15 - idx) : 0;
    endfunction

    function automatic logic [31:0] active_vec();
        logic [31:0] v;
        v = '0;
        for (int m = 0; m < NM; m++) v[m*4 +: 4] = 4'(exp_active[m]);
        return v;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < NM; m++) begin
            exp_shadow[m] = 0;
            exp_active[m] = 0;
        end
        exp_mask = '0;
        exp_err  = 1'b0;
    endfunction

    task automatic do_write(input int addr, input int idx);
        logic [31:0] a;
        logic [31:0] i;
        a = addr;
        i = idx;
        @(negedge prog_clk);
        n_checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_ready_idle: got %b expected 1", bus_if.wr_ready);
        end
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = a[2:0];
        bus_if.wr_idx   = i[4:0];
        @(negedge prog_clk);
        bus_if.wr_valid = 1'b0;
        if (addr < NM) begin
            exp_shadow[addr] = code_of(idx);
            exp_mask[addr]   = 1'b1;
        end
        if (idx >= 15 || addr >= NM) exp_err = 1'b1;
        n_checks++;
        if (bus_if.written_mask !== exp_mask) begin
            n_errors++;
            $display("FAIL write_mask a=%0d i=%0d: got %h expected %h", addr, idx,
                     bus_if.written_mask, exp_mask);
        end
        n_checks++;
        if (bus_if.cfg_done !== (&exp_mask)) begin
            n_errors++;
            $display("FAIL write_cfg_done: got %b expected %b", bus_if.cfg_done, &exp_mask);
        end
        n_checks++;
        if (bus_if.cfg_err !== exp_err) begin
            n_errors++;
            $display("FAIL write_cfg_err a=%0d i=%0d: got %b expected %b", addr, idx,
                     bus_if.cfg_err, exp_err);
        end
        n_checks++;
        if (bus_if.sram !== active_vec()) begin
            n_errors++;
            $display("FAIL write_sram_stable: got %h expected %h", bus_if.sram, active_vec());
        end
    endtask

    task automatic do_commit();
        @(negedge prog_clk);
        bus_if.commit_req = 1'b1;
        @(negedge prog_clk);
        bus_if.commit_req = 1'b0;
        n_checks++;
        if (bus_if.wr_ready !== 1'b0 || bus_if.commit_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL commit_phase1: got ready=%b ack=%b expected ready=0 ack=0",
                     bus_if.wr_ready, bus_if.commit_ack);
        end
        n_checks++;
        if (bus_if.sram !== active_vec()) begin
            n_errors++;
            $display("FAIL commit_sram_early: got %h expected %h", bus_if.sram, active_vec());
        end
        @(negedge prog_clk);
        for (int m = 0; m < NM; m++) exp_active[m] = exp_shadow[m];
        exp_mask = '0;
        n_checks++;
        if (bus_if.commit_ack !== 1'b1 || bus_if.wr_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL commit_ack_pulse: got ack=%b ready=%b expected ack=1 ready=0",
                     bus_if.commit_ack, bus_if.wr_ready);
        end
        n_checks++;
        if (bus_if.sram !== active_vec()) begin
            n_errors++;
            $display("FAIL commit_sram: got %h expected %h", bus_if.sram, active_vec());
        end
        n_checks++;
        if (bus_if.sram_inv !== ~active_vec()) begin
            n_errors++;
            $display("FAIL commit_sram_inv: got %h expected %h", bus_if.sram_inv, ~active_vec());
        end
        n_checks++;
        if (bus_if.written_mask !== 8'h00 || bus_if.cfg_done !== 1'b0) begin
            n_errors++;
            $display("FAIL commit_mask_clear: got mask=%h done=%b expected 00/0",
                     bus_if.written_mask, bus_if.cfg_done);
        end
        @(negedge prog_clk);
        n_checks++;
        if (bus_if.commit_ack !== 1'b0 || bus_if.wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL commit_return_idle: got ack=%b ready=%b expected ack=0 ready=1",
                     bus_if.commit_ack, bus_if.wr_ready);
        end
        n_checks++;
        if (bus_if.cfg_err !== exp_err) begin
            n_errors++;
            $display("FAIL commit_cfg_err: got %b expected %b", bus_if.cfg_err, exp_err);
        end
    endtask

    task automatic test_reset();
        @(posedge prog_clk);
        #3 pReset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (bus_if.sram !== 32'h0 || bus_if.sram_inv !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL reset_sram: got sram=%h inv=%h expected 0/ffffffff",
                     bus_if.sram, bus_if.sram_inv);
        end
        n_checks++;
        if (bus_if.written_mask !== 8'h00 || bus_if.cfg_done !== 1'b0 ||
            bus_if.cfg_err !== 1'b0 || bus_if.commit_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got mask=%h done=%b err=%b ack=%b expected 0",
                     bus_if.written_mask, bus_if.cfg_done, bus_if.cfg_err, bus_if.commit_ack);
        end
        repeat (2) @(negedge prog_clk);
        pReset = 1'b0;
        @(negedge prog_clk);
        n_checks++;
        if (bus_if.wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_wr_ready: got %b expected 1", bus_if.wr_ready);
        end
    endtask

    task automatic test_full_load();
        for (int m = 0; m < NM; m++) begin
            if (m == NM - 1) begin
                n_checks++;
                if (bus_if.cfg_done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL full_load_done_early: got %b expected 0", bus_if.cfg_done);
                end
            end
            do_write(m, m);
        end
        n_checks++;
        if (bus_if.cfg_done !== 1'b1) begin
            n_errors++;
            $display("FAIL full_load_done: got %b expected 1", bus_if.cfg_done);
        end
        do_commit();
        n_checks++;
        if (bus_if.sram[3:0] !== 4'd15 || bus_if.sram[31:28] !== 4'd8) begin
            n_errors++;
            $display("FAIL full_load_codes: got mux0=%0d mux7=%0d expected 15/8",
                     bus_if.sram[3:0], bus_if.sram[31:28]);
        end
    endtask

    task automatic test_error();
        do_write(3, 15);
        do_commit();
        n_checks++;
        if (bus_if.sram[15:12] !== 4'd0) begin
            n_errors++;
            $display("FAIL error_mux3_code: got %0d expected 0", bus_if.sram[15:12]);
        end
        do_commit();
        n_checks++;
        if (bus_if.cfg_err !== 1'b1) begin
            n_errors++;
            $display("FAIL error_sticky: got %b expected 1", bus_if.cfg_err);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge prog_clk);
        bus_if.wr_valid   = 1'b1;
        bus_if.wr_addr    = 3'd5;
        bus_if.wr_idx     = 5'd2;
        bus_if.commit_req = 1'b1;
        @(negedge prog_clk);
        exp_shadow[5]     = code_of(2);
        bus_if.commit_req = 1'b0;
        // Keep offering a write to mux6 through COMMIT and ACK; it must be refused.
        bus_if.wr_addr    = 3'd6;
        bus_if.wr_idx     = 5'd0;
        n_checks++;
        if (bus_if.wr_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_ready_commit: got %b expected 0", bus_if.wr_ready);
        end
        @(negedge prog_clk);
        for (int m = 0; m < NM; m++) exp_active[m] = exp_shadow[m];
        exp_mask = '0;
        n_checks++;
        if (bus_if.wr_ready !== 1'b0 || bus_if.commit_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_ack: got ready=%b ack=%b expected 0/1",
                     bus_if.wr_ready, bus_if.commit_ack);
        end
        n_checks++;
        if (bus_if.sram[23:20] !== 4'd13 || bus_if.sram !== active_vec()) begin
            n_errors++;
            $display("FAIL simul_sram: got %h expected %h (mux5=13)", bus_if.sram, active_vec());
        end
        bus_if.wr_valid = 1'b0;
        @(negedge prog_clk);
        n_checks++;
        if (bus_if.written_mask !== 8'h00) begin
            n_errors++;
            $display("FAIL simul_refused_write: got mask=%h expected 00", bus_if.written_mask);
        end
        do_commit();
    endtask

    task automatic test_overwrite_hold();
        int acks;
        do_write(1, 4);
        do_write(1, 9);
        acks = 0;
        @(negedge prog_clk);
        bus_if.commit_req = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge prog_clk);
            if (c == 5) bus_if.commit_req = 1'b0;
            if (bus_if.commit_ack === 1'b1) acks++;
        end
        for (int m = 0; m < NM; m++) exp_active[m] = exp_shadow[m];
        exp_mask = '0;
        n_checks++;
        if (acks != 2) begin
            n_errors++;
            $display("FAIL hold_ack_count: got %0d expected 2", acks);
        end
        n_checks++;
        if (bus_if.sram[7:4] !== 4'd6 || bus_if.sram !== active_vec()) begin
            n_errors++;
            $display("FAIL hold_sram: got %h expected %h (mux1=6)", bus_if.sram, active_vec());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) do_commit();
            else do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 17)));
        end
    endtask

    task automatic test_reset_during_commit();
        int acks;
        logic bad_sram;
        do_write(2, 0);
        @(negedge prog_clk);
        bus_if.commit_req = 1'b1;
        @(negedge prog_clk);
        bus_if.commit_req = 1'b0;
        #1 pReset = 1'b1;
        model_reset();
        acks     = 0;
        bad_sram = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge prog_clk);
            if (c == 2) pReset = 1'b0;
            if (bus_if.commit_ack === 1'b1) acks++;
            if (bus_if.sram !== 32'h0 || bus_if.sram_inv !== 32'hFFFF_FFFF) bad_sram = 1'b1;
        end
        n_checks++;
        if (acks != 0) begin
            n_errors++;
            $display("FAIL rst_commit_ack: got %0d pulses expected 0", acks);
        end
        n_checks++;
        if (bad_sram !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_commit_sram: got sram=%h expected 0", bus_if.sram);
        end
        n_checks++;
        if (bus_if.written_mask !== 8'h00 || bus_if.cfg_err !== 1'b0 ||
            bus_if.wr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_commit_state: got mask=%h err=%b ready=%b expected 00/0/1",
                     bus_if.written_mask, bus_if.cfg_err, bus_if.wr_ready);
        end
    endtask

    initial begin
        pReset            = 1'b1;
        bus_if.wr_valid   = 1'b0;
        bus_if.wr_addr    = '0;
        bus_if.wr_idx     = '0;
        bus_if.commit_req = 1'b0;
        model_reset();
        repeat (2) @(negedge prog_clk);
        pReset = 1'b0;

        test_reset();
        test_full_load();
        test_error();
        test_simultaneous();
        test_overwrite_hold();
        test_random();
        test_reset_during_commit();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_cfg_loader.md
# mux_cfg_loader

Configuration front-end that programs a bank of routing mux trees (15-input, 4-bit select, OpenFPGA-style tree with `const1` tie-off) from an index-based write stream. Host writes a per-mux input index into a shadow bank via valid/ready; a commit handshake atomically transfers the shadow bank to the registered `sram`/`sram_inv` buses, which drive the mux trees' select ports directly. Sits directly upstream of the `mux_tree_tapbuf` instances in each switch/connection block.

## Interface
- `NUM_MUX`, 8, number of mux trees driven
- `MUX_SIZE`, 15, data inputs per mux tree
- `SEL_W`, 4, select bits per mux; must equal clog2(`MUX_SIZE`+1)
- `ADDR_W`, 3, mux address width; clog2(`NUM_MUX`)
- `IDX_W`, 5, index width; `SEL_W`+1

- `prog_clk`  in  1  programming clock; all state on rising edge
- `pReset`  in  1  asynchronous, active-high reset
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  loader can accept a write
- `wr_addr`  in  `ADDR_W`  target mux number
- `wr_idx`  in  `IDX_W`  selected data input index of target mux
- `commit_req`  in  1  request shadow-to-active transfer
- `commit_ack`  out  1  one-cycle pulse: transfer completed
- `sram`  out  `NUM_MUX`*`SEL_W`  active select bits; mux m on bits [m*SEL_W +: SEL_W]
- `sram_inv`  out  `NUM_MUX`*`SEL_W`  bitwise complement of `sram`, separately registered
- `written_mask`  out  `NUM_MUX`  bit m set once mux m written since last commit
- `cfg_done`  out  1  all bits of `written_mask` set
- `cfg_err`  out  1  sticky error flag

## Operation
- Encoding: index i in 0..`MUX_SIZE`-1 maps to code `MUX_SIZE`-i (in[0]→15, in[14]→1). Code 0 selects the tree's `const1` leaf (safe default).
- Write accepted when `wr_valid && wr_ready`: shadow[wr_addr] ← code, written_mask[wr_addr] ← 1.
- `wr_idx` ≥ `MUX_SIZE`: write still accepted, shadow stores 0, mask bit set, `cfg_err` ← 1.
- `wr_addr` ≥ `NUM_MUX` (non-power-of-two bank): write accepted and discarded, `cfg_err` ← 1, no mask change.
- Same address written twice before commit: last write wins.
- FSM states IDLE, COMMIT, ACK.
  - IDLE: `wr_ready`=1. `commit_req`=1 → COMMIT.
  - COMMIT: `wr_ready`=0; on exit edge active ← shadow, `sram_inv` ← ~shadow, written_mask ← 0 → ACK.
  - ACK: `wr_ready`=0, `commit_ack`=1 → IDLE.
- `commit_req` sampled only in IDLE; held high re-triggers a new commit after ACK.
- Write and `commit_req` in the same IDLE cycle: write accepted and included in that commit.
- Shadow is not cleared by commit; uncommitted entries retain previous shadow values.
- `cfg_err` cleared only by `pReset`.

## Timing
- Reset (async assert, sync-safe deassert into IDLE): `sram`=0, `sram_inv`=all ones, shadow=0, `written_mask`=0, `cfg_done`=0, `cfg_err`=0, `commit_ack`=0, `wr_ready`=1 once released. All trees output `const1`.
- Write latency: shadow/mask update on accepting edge; `cfg_done` valid the following cycle (combinational AND of mask register).
- Commit latency: `commit_req` sampled at edge T → `sram`/`sram_inv` change at T+1 → `commit_ack` high during cycle T+1..T+2 → IDLE at T+2. `wr_ready` low for exactly two cycles.
- `sram` and `sram_inv` always change on the same edge; `sram ^ sram_inv` is all ones at every edge.
- `pReset` during COMMIT or ACK: immediate return to reset values; no partial transfer visible.

## Test plan
- Reset: assert `pReset` mid-cycle → `sram`=0, `sram_inv`=0xFFFF_FFFF (default params), `wr_ready`=1 after release, `cfg_err`=0.
- Full load: write mux m idx m for m=0..7, commit → `cfg_done`=1 before commit; mux0 code 15, mux7 code 8; `commit_ack` pulse 2 cycles after req; mask cleared.
- Error: write mux3 idx 15 → `cfg_err`=1, after commit mux3 code 0; other muxes unaffected; `cfg_err` stays 1 after next commit.
- Simultaneous: write mux5 idx 2 with `commit_req` same cycle → post-commit mux5 code 13; `wr_valid` during COMMIT/ACK not accepted (`wr_ready`=0).
- Overwrite and hold: write mux1 idx 4 then idx 9, hold `commit_req` high 6 cycles → mux1 code 6; two `commit_ack` pulses.
- Reset during COMMIT → `sram` remains 0, `commit_ack` never pulses.
